// File: rtl/imm_pipe_gen_pkg.sv
// -----------------------------------------------------------------------------
// imm_pipe_gen_pkg
// Shared definitions for the immediate generator pipeline:
//   - imm_fmt_e : 3-bit immediate format code reported on out_fmt_o
//   - OPC_*     : RV32I major opcode constants (instr[6:0])
// No ports (package).
// -----------------------------------------------------------------------------
package imm_pipe_gen_pkg;

   typedef enum logic [2:0] {
      FMT_NONE = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5,
      FMT_Z    = 3'd6
   } imm_fmt_e;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/imm_pipe_gen_extract.sv
// -----------------------------------------------------------------------------
// imm_extract
// Purely combinational decode of one RV32I instruction word into its
// sign-extended immediate, format code and an "unsupported encoding" flag.
// Optional feature macro: IMM_PIPE_GEN_ZICSR_EN (CSR immediate forms).
// Ports:
//   instr_i   in  32    raw instruction word
//   imm_o     out XLEN  extended immediate (0 for NONE/illegal)
//   fmt_o     out 3     imm_fmt_e format code
//   illegal_o out 1     encoding not supported
// -----------------------------------------------------------------------------
module imm_extract
   import imm_pipe_gen_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]      instr_i,
   output logic [XLEN-1:0]  imm_o,
   output imm_fmt_e         fmt_o,
   output logic             illegal_o
);

   logic signed [31:0]      imm32;
   logic signed [XLEN-1:0]  imm_sx;
   logic [XLEN-1:0]         imm_zx;
   logic [31:0]             i_imm;

   assign i_imm = {{20{instr_i[31]}}, instr_i[31:20]};

   always_comb begin
      fmt_o     = FMT_NONE;
      illegal_o = 1'b0;
      imm32     = '0;
      if (instr_i[1:0] != 2'b11) begin
         illegal_o = 1'b1;
      end else begin
         unique case (instr_i[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
               fmt_o = FMT_I;
               imm32 = i_imm;
            end
            OPC_STORE: begin
               fmt_o = FMT_S;
               imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            end
            OPC_BRANCH: begin
               fmt_o = FMT_B;
               imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                        instr_i[30:25], instr_i[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
               fmt_o = FMT_U;
               imm32 = {instr_i[31:12], 12'b0};
            end
            OPC_JAL: begin
               fmt_o = FMT_J;
               imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                        instr_i[20], instr_i[30:21], 1'b0};
            end
            OPC_OP, OPC_FENCE: begin
               fmt_o = FMT_NONE;
            end
            OPC_SYSTEM: begin
`ifdef IMM_PIPE_GEN_ZICSR_EN
               // funct3[2] selects the CSR-immediate forms (uimm in rs1 field);
               // other non-zero funct3 are register CSR ops carrying the CSR
               // address as an I-type immediate. funct3==0 (ecall etc.) has none.
               if (instr_i[14]) begin
                  fmt_o = FMT_Z;
               end else if (instr_i[13:12] != 2'b00) begin
                  fmt_o = FMT_I;
                  imm32 = i_imm;
               end
`else
               fmt_o = FMT_NONE;
`endif
            end
            default: begin
               illegal_o = 1'b1;
            end
         endcase
      end
   end

   // Separate statements keep the signed extension out of any mixed-sign
   // expression context, so U-type on XLEN=64 sign-extends from bit 31.
   always_comb begin
      imm_sx = XLEN'(imm32);
      imm_zx = XLEN'(instr_i[19:15]);
      imm_o  = (fmt_o == FMT_Z) ? imm_zx : imm_sx;
   end

endmodule

// File: rtl/imm_pipe_gen.sv
// -----------------------------------------------------------------------------
// imm_pipe_gen
// One-stage valid/ready pipeline around imm_extract with a skid register so
// in_ready_o comes straight from a flop. Also counts delivered illegal results.
// Optional feature macro: IMM_PIPE_GEN_ZICSR_EN (passed through to imm_extract).
// Ports:
//   clk_i, rst_ni            clock (rising) / async active-low reset
//   in_valid_i/in_ready_o    input handshake
//   in_instr_i, in_tag_i     instruction word and opaque tag
//   out_valid_o/out_ready_i  output handshake
//   out_imm_o, out_fmt_o, out_illegal_o, out_tag_o   result fields
//   illegal_cnt_o            saturating count of illegal results delivered
// -----------------------------------------------------------------------------
module imm_pipe_gen
   import imm_pipe_gen_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [31:0]       in_instr_i,
   input  logic [TAG_W-1:0]  in_tag_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [XLEN-1:0]   out_imm_o,
   output logic [2:0]        out_fmt_o,
   output logic              out_illegal_o,
   output logic [TAG_W-1:0]  out_tag_o,
   output logic [15:0]       illegal_cnt_o
);

   typedef struct packed {
      logic [XLEN-1:0]  imm;
      imm_fmt_e         fmt;
      logic             ill;
      logic [TAG_W-1:0] tag;
   } entry_t;

   entry_t      in_entry;
   imm_fmt_e    ext_fmt;
   entry_t      out_q, out_d, skid_q, skid_d;
   logic        out_valid_q, out_valid_d;
   logic        skid_valid_q, skid_valid_d;
   logic        in_ready_q, in_ready_d;
   logic [15:0] cnt_q, cnt_d;
   logic        in_fire, out_fire;

   imm_extract #(.XLEN(XLEN)) u_extract (
      .instr_i   (in_instr_i),
      .imm_o     (in_entry.imm),
      .fmt_o     (ext_fmt),
      .illegal_o (in_entry.ill)
   );

   assign in_entry.fmt = ext_fmt;
   assign in_entry.tag = in_tag_i;

   assign in_fire  = in_valid_i & in_ready_q;
   assign out_fire = out_valid_q & out_ready_i;

   always_comb begin
      out_d        = out_q;
      out_valid_d  = out_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      cnt_d        = cnt_q;

      if (!out_valid_q || out_fire) begin
         // Output slot frees up: the older skid entry has priority. While the
         // skid is full in_ready is low, so no input can arrive concurrently.
         if (skid_valid_q) begin
            out_d        = skid_q;
            out_valid_d  = 1'b1;
            skid_valid_d = 1'b0;
         end else if (in_fire) begin
            out_d       = in_entry;
            out_valid_d = 1'b1;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (in_fire) begin
         skid_d       = in_entry;
         skid_valid_d = 1'b1;
      end

      in_ready_d = ~skid_valid_d;

      if (out_fire && out_q.ill && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         out_q        <= '0;
         out_valid_q  <= 1'b0;
         skid_q       <= '0;
         skid_valid_q <= 1'b0;
         in_ready_q   <= 1'b1;
         cnt_q        <= '0;
      end else begin
         out_q        <= out_d;
         out_valid_q  <= out_valid_d;
         skid_q       <= skid_d;
         skid_valid_q <= skid_valid_d;
         in_ready_q   <= in_ready_d;
         cnt_q        <= cnt_d;
      end
   end

   assign in_ready_o    = in_ready_q;
   assign out_valid_o   = out_valid_q;
   assign out_imm_o     = out_q.imm;
   assign out_fmt_o     = out_q.fmt;
   assign out_illegal_o = out_q.ill;
   assign out_tag_o     = out_q.tag;
   assign illegal_cnt_o = cnt_q;

endmodule

// File: tb/tb_imm_pipe_gen.sv
module tb_imm_pipe_gen;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [3:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_imm;
   logic [2:0]  out_fmt;
   logic        out_illegal;
   logic [3:0]  out_tag;
   logic [15:0] illegal_cnt;

   // XLEN=64 instance
   logic        in_valid64;
   logic        in_ready64;
   logic [31:0] in_instr64;
   logic        out_valid64;
   logic [63:0] out_imm64;
   logic [2:0]  out_fmt64;
   logic        out_illegal64;
   logic [3:0]  out_tag64;
   logic [15:0] illegal_cnt64;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   imm_pipe_gen #(.XLEN(32), .TAG_W(4)) dut (
      .clk_i         (clk),
      .rst_ni        (rst_ni),
      .in_valid_i    (in_valid),
      .in_ready_o    (in_ready),
      .in_instr_i    (in_instr),
      .in_tag_i      (in_tag),
      .out_valid_o   (out_valid),
      .out_ready_i   (out_ready),
      .out_imm_o     (out_imm),
      .out_fmt_o     (out_fmt),
      .out_illegal_o (out_illegal),
      .out_tag_o     (out_tag),
      .illegal_cnt_o (illegal_cnt)
   );

   imm_pipe_gen #(.XLEN(64), .TAG_W(4)) dut64 (
      .clk_i         (clk),
      .rst_ni        (rst_ni),
      .in_valid_i    (in_valid64),
      .in_ready_o    (in_ready64),
      .in_instr_i    (in_instr64),
      .in_tag_i      (4'd0),
      .out_valid_o   (out_valid64),
      .out_ready_i   (1'b1),
      .out_imm_o     (out_imm64),
      .out_fmt_o     (out_fmt64),
      .out_illegal_o (out_illegal64),
      .out_tag_o     (out_tag64),
      .illegal_cnt_o (illegal_cnt64)
   );

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst_ni = 1'b0; in_valid = 1'b0; in_instr = '0; in_tag = '0; out_ready = 1'b0;
      in_valid64 = 1'b0; in_instr64 = '0;
      tick; tick;
      checks++;
      if ({out_valid, in_ready, out_imm, out_fmt, out_illegal, out_tag, illegal_cnt} !==
          {1'b0, 1'b1, 32'd0, 3'd0, 1'b0, 4'd0, 16'd0}) begin
         errors++;
         $display("FAIL reset_state: valid=%0b ready=%0b imm=%h fmt=%0d ill=%0b tag=%0d cnt=%0d, required 0 1 0 0 0 0 0",
                  out_valid, in_ready, out_imm, out_fmt, out_illegal, out_tag, illegal_cnt);
      end
      rst_ni = 1'b1;
   endtask

   task automatic test_addi;
      out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'hFFF00093; in_tag = 4'd3;
      tick;
      in_valid = 1'b0;
      checks++;
      if ({out_valid, out_imm, out_fmt, out_illegal, out_tag} !== {1'b1, 32'hFFFFFFFF, 3'd1, 1'b0, 4'd3}) begin
         errors++;
         $display("FAIL addi: valid=%0b imm=%h fmt=%0d ill=%0b tag=%0d, required 1 ffffffff 1 0 3",
                  out_valid, out_imm, out_fmt, out_illegal, out_tag);
      end
      $display("txn addi tag=%0d imm=%h fmt=%0d", out_tag, out_imm, out_fmt);
      tick;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL addi_drain: valid=%0b, required 0", out_valid);
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] v_instr [11];
      logic [31:0] v_imm   [11];
      logic [2:0]  v_fmt   [11];
      v_instr[0]  = 32'hFFF00093; v_imm[0]  = 32'hFFFFFFFF; v_fmt[0]  = 3'd1;
      v_instr[1]  = 32'hFE000EE3; v_imm[1]  = 32'hFFFFFFFC; v_fmt[1]  = 3'd3;
      v_instr[2]  = 32'h00112223; v_imm[2]  = 32'h00000004; v_fmt[2]  = 3'd2;
      v_instr[3]  = 32'h008000EF; v_imm[3]  = 32'h00000008; v_fmt[3]  = 3'd5;
      v_instr[4]  = 32'h80000037; v_imm[4]  = 32'h80000000; v_fmt[4]  = 3'd4;
      v_instr[5]  = 32'h002081B3; v_imm[5]  = 32'h00000000; v_fmt[5]  = 3'd0;
`ifdef IMM_PIPE_GEN_ZICSR_EN
      v_instr[6]  = 32'h3002D073; v_imm[6]  = 32'h00000005; v_fmt[6]  = 3'd6;
      v_instr[7]  = 32'h300020F3; v_imm[7]  = 32'h00000300; v_fmt[7]  = 3'd1;
`else
      v_instr[6]  = 32'h3002D073; v_imm[6]  = 32'h00000000; v_fmt[6]  = 3'd0;
      v_instr[7]  = 32'h300020F3; v_imm[7]  = 32'h00000000; v_fmt[7]  = 3'd0;
`endif
      v_instr[8]  = 32'h00000073; v_imm[8]  = 32'h00000000; v_fmt[8]  = 3'd0;
      v_instr[9]  = 32'h0000000F; v_imm[9]  = 32'h00000000; v_fmt[9]  = 3'd0;
      v_instr[10] = 32'h00001017; v_imm[10] = 32'h00001000; v_fmt[10] = 3'd4;
      out_ready = 1'b1;
      for (int i = 0; i <= 11; i++) begin
         if (i > 0) begin
            checks++;
            if ({out_valid, out_imm, out_fmt, out_illegal, out_tag} !==
                {1'b1, v_imm[i-1], v_fmt[i-1], 1'b0, 4'(i-1)}) begin
               errors++;
               $display("FAIL b2b[%0d]: valid=%0b imm=%h fmt=%0d ill=%0b tag=%0d, required 1 %h %0d 0 %0d",
                        i-1, out_valid, out_imm, out_fmt, out_illegal, out_tag, v_imm[i-1], v_fmt[i-1], i-1);
            end
            $display("txn b2b tag=%0d instr=%h imm=%h fmt=%0d", out_tag, v_instr[i-1], out_imm, out_fmt);
         end
         if (i < 11) begin
            in_valid = 1'b1; in_instr = v_instr[i]; in_tag = 4'(i);
         end else begin
            in_valid = 1'b0;
         end
         tick;
      end
   endtask

   task automatic test_backpressure;
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = 32'hFFF00093; in_tag = 4'd1;
      tick;
      checks++;
      if ({in_ready, out_valid, out_tag} !== {1'b1, 1'b1, 4'd1}) begin
         errors++;
         $display("FAIL bp_first: ready=%0b valid=%0b tag=%0d, required 1 1 1", in_ready, out_valid, out_tag);
      end
      in_instr = 32'hFE000EE3; in_tag = 4'd2;
      tick;
      // tag 7 offered while full: must not be taken
      in_instr = 32'h00112223; in_tag = 4'd7;
      checks++;
      if ({in_ready, out_valid, out_tag, out_imm} !== {1'b0, 1'b1, 4'd1, 32'hFFFFFFFF}) begin
         errors++;
         $display("FAIL bp_full: ready=%0b valid=%0b tag=%0d imm=%h, required 0 1 1 ffffffff",
                  in_ready, out_valid, out_tag, out_imm);
      end
      tick;
      checks++;
      if ({in_ready, out_valid, out_tag} !== {1'b0, 1'b1, 4'd1}) begin
         errors++;
         $display("FAIL bp_hold: ready=%0b valid=%0b tag=%0d, required 0 1 1", in_ready, out_valid, out_tag);
      end
      out_ready = 1'b1;
      tick;
      in_valid = 1'b0;
      $display("txn bp tag=1 delivered");
      checks++;
      if ({in_ready, out_valid, out_tag, out_imm, out_fmt} !== {1'b1, 1'b1, 4'd2, 32'hFFFFFFFC, 3'd3}) begin
         errors++;
         $display("FAIL bp_second: ready=%0b valid=%0b tag=%0d imm=%h fmt=%0d, required 1 1 2 fffffffc 3",
                  in_ready, out_valid, out_tag, out_imm, out_fmt);
      end
      tick;
      $display("txn bp tag=2 delivered");
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_nodup: valid=%0b tag=%0d, required valid 0", out_valid, out_tag);
      end
   endtask

   task automatic test_illegal;
      out_ready = 1'b1;
      in_valid = 1'b1; in_instr = 32'h00000000; in_tag = 4'd5;
      tick;
      in_valid = 1'b0;
      checks++;
      if ({out_valid, out_illegal, out_fmt, out_imm} !== {1'b1, 1'b1, 3'd0, 32'd0}) begin
         errors++;
         $display("FAIL illegal_zero: valid=%0b ill=%0b fmt=%0d imm=%h, required 1 1 0 0",
                  out_valid, out_illegal, out_fmt, out_imm);
      end
      tick;
      checks++;
      if (illegal_cnt !== 16'd1) begin
         errors++;
         $display("FAIL illegal_cnt1: cnt=%0d, required 1", illegal_cnt);
      end
      in_valid = 1'b1; in_instr = 32'h0000007F;
      for (int k = 0; k < 65534; k++) tick;
      in_valid = 1'b0;
      tick; tick;
      checks++;
      if (illegal_cnt !== 16'hFFFF) begin
         errors++;
         $display("FAIL illegal_cnt_max: cnt=%h, required ffff", illegal_cnt);
      end
      in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      tick; tick;
      checks++;
      if (illegal_cnt !== 16'hFFFF) begin
         errors++;
         $display("FAIL illegal_cnt_sat: cnt=%h, required ffff", illegal_cnt);
      end
   endtask

   task automatic test_reset_midop;
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = 32'hFFF00093; in_tag = 4'd1;
      tick;
      in_tag = 4'd2;
      tick;
      in_valid = 1'b0;
      checks++;
      if ({in_ready, out_valid} !== {1'b0, 1'b1}) begin
         errors++;
         $display("FAIL midop_full: ready=%0b valid=%0b, required 0 1", in_ready, out_valid);
      end
      #2 rst_ni = 1'b0;
      #1;
      checks++;
      if ({out_valid, in_ready, out_tag, illegal_cnt} !== {1'b0, 1'b1, 4'd0, 16'd0}) begin
         errors++;
         $display("FAIL midop_reset: valid=%0b ready=%0b tag=%0d cnt=%0d, required 0 1 0 0",
                  out_valid, in_ready, out_tag, illegal_cnt);
      end
      tick;
      rst_ni = 1'b1; out_ready = 1'b1;
      in_valid = 1'b1; in_instr = 32'h00112223; in_tag = 4'd9;
      tick;
      in_valid = 1'b0;
      checks++;
      if ({out_valid, out_tag, out_imm, out_fmt} !== {1'b1, 4'd9, 32'd4, 3'd2}) begin
         errors++;
         $display("FAIL midop_first_accept: valid=%0b tag=%0d imm=%h fmt=%0d, required 1 9 4 2",
                  out_valid, out_tag, out_imm, out_fmt);
      end
      tick;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL midop_discard: valid=%0b tag=%0d, required valid 0", out_valid, out_tag);
      end
   endtask

   task automatic test_xlen64;
      in_valid64 = 1'b1; in_instr64 = 32'h80000037;
      tick;
      in_instr64 = 32'hFFF00093;
      checks++;
      if ({out_valid64, out_imm64, out_fmt64, out_illegal64} !== {1'b1, 64'hFFFFFFFF80000000, 3'd4, 1'b0}) begin
         errors++;
         $display("FAIL x64_lui: valid=%0b imm=%h fmt=%0d ill=%0b, required 1 ffffffff80000000 4 0",
                  out_valid64, out_imm64, out_fmt64, out_illegal64);
      end
      $display("txn x64 lui imm=%h", out_imm64);
      tick;
      in_valid64 = 1'b0;
      checks++;
      if ({out_valid64, out_imm64, out_fmt64} !== {1'b1, 64'hFFFFFFFFFFFFFFFF, 3'd1}) begin
         errors++;
         $display("FAIL x64_addi: valid=%0b imm=%h fmt=%0d, required 1 ffffffffffffffff 1",
                  out_valid64, out_imm64, out_fmt64);
      end
      $display("txn x64 addi imm=%h", out_imm64);
      tick;
   endtask

   initial begin
      test_reset;
      test_addi;
      test_back_to_back;
      test_backpressure;
      test_xlen64;
      test_illegal;
      test_reset_midop;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
